// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral register bus, with registered read return.
// Define PERIPH_ARB_LOCK_LIMIT_EN to bound a locked owner to MAX_LOCK transfers while the other master waits.
module periph_bus_arbiter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_A,
    input  logic [DATA_W-1:0] m0_WD,
    input  logic              m0_WE,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_RD,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_A,
    input  logic [DATA_W-1:0] m1_WD,
    input  logic              m1_WE,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_RD,
    output logic [ADDR_W-1:0] p_A,
    output logic [DATA_W-1:0] p_WD,
    output logic              p_WE,
    input  logic [DATA_W-1:0] p_RD
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;
    logic   xfer0, xfer1;
    logic   hold;
    logic   lock_exh;

    if (MAX_LOCK == 0) begin : g_bad_max_lock
        $error("MAX_LOCK must be at least 1");
    end

    assign m0_gnt = (state == OWN0);
    assign m1_gnt = (state == OWN1);

    always_comb begin
        xfer0    = (state == OWN0) && m0_req;
        xfer1    = (state == OWN1) && m1_req;
        last_nxt = last;
        if (xfer0) begin
            last_nxt = 1'b0;
        end else if (xfer1) begin
            last_nxt = 1'b1;
        end
    end

    always_comb begin
        p_A  = '0;
        p_WD = '0;
        p_WE = 1'b0;
        if (xfer0) begin
            p_A  = m0_A;
            p_WD = m0_WD;
            p_WE = m0_WE;
        end else if (xfer1) begin
            p_A  = m1_A;
            p_WD = m1_WD;
            p_WE = m1_WE;
        end
    end

    // Round-robin uses the owner of this cycle's transfer, so a completing master yields on a tie.
    always_comb begin
        hold      = ((xfer0 && m0_lock) || (xfer1 && m1_lock)) && !lock_exh;
        state_nxt = IDLE;
        if (hold) begin
            state_nxt = state;
        end else if (m0_req && m1_req) begin
            state_nxt = last_nxt ? OWN0 : OWN1;
        end else if (m0_req) begin
            state_nxt = OWN0;
        end else if (m1_req) begin
            state_nxt = OWN1;
        end
    end

`ifdef PERIPH_ARB_LOCK_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    logic [CNT_W-1:0] lock_cnt, lock_cnt_inc, lock_cnt_nxt;
    logic             locked_xfer;

    // Exhaustion is judged on the count including this transfer, giving exactly MAX_LOCK locked transfers.
    always_comb begin
        locked_xfer  = (xfer0 && m0_lock && m1_req) || (xfer1 && m1_lock && m0_req);
        lock_cnt_inc = locked_xfer ? (lock_cnt + 1'b1) : '0;
        lock_exh     = locked_xfer && (lock_cnt_inc == CNT_W'(MAX_LOCK));
    end

    always_comb begin
        lock_cnt_nxt = (state_nxt == state) ? lock_cnt_inc : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt_nxt;
        end
    end
`else
    assign lock_exh = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_RD     <= '0;
            m1_RD     <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            m0_rvalid <= xfer0;
            m1_rvalid <= xfer1;
            if (xfer0) begin
                m0_RD <= p_RD;
            end
            if (xfer1) begin
                m1_RD <= p_RD;
            end
        end
    end

endmodule
